// File: rtl/rs_encoder_if.sv
// rs_encoder_if: byte-stream bundle for the RS(255,247) encoder.
//   din_val/din_sop/din_eop/din   : message byte stream into the encoder
//   dout_val/dout_sop/dout_eop/dout : codeword byte stream out of the encoder
//   busy, len_err, sop_err        : encoder status
// slave  = encoder side, master = source/sink side.
interface rs_encoder_if;
    logic       din_val;
    logic       din_sop;
    logic       din_eop;
    logic [7:0] din;
    logic       dout_val;
    logic       dout_sop;
    logic       dout_eop;
    logic [7:0] dout;
    logic       busy;
    logic       len_err;
    logic       sop_err;

    modport master (
        output din_val, din_sop, din_eop, din,
        input  dout_val, dout_sop, dout_eop, dout, busy, len_err, sop_err
    );

    modport slave (
        input  din_val, din_sop, din_eop, din,
        output dout_val, dout_sop, dout_eop, dout, busy, len_err, sop_err
    );
endinterface

// File: rtl/rs_encoder.sv
// rs_encoder: systematic RS(255,247,T=4) encoder over GF(256), p(x)=0x11D,
// g(x) with roots a^1..a^8. Message bytes pass through one cycle after
// acceptance, then 8 parity bytes follow gaplessly. Shortened messages of
// 1..K bytes are supported; length is set by din_eop.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   io   - rs_encoder_if.slave: din_* in, dout_* out, busy/len_err/sop_err
//
// state  | meaning
// IDLE   | waiting for din_val & din_sop
// DATA   | accepting message bytes, LFSR dividing by g(x)
// PARITY | shifting the 8 remainder bytes out, input discarded
module rs_encoder #(
    parameter int K    = 247,
    parameter int NPAR = 8
) (
    input logic        clk,
    input logic        rst,
    rs_encoder_if.slave io
);
    localparam int CW = $clog2(K + 1);
    localparam int PW = $clog2(NPAR);

    // g(x) coefficients, index i is the coefficient of x^i (x^8 is monic)
    localparam logic [7:0][7:0] G = {8'he3, 8'h2c, 8'hb2, 8'h47,
                                     8'hac, 8'h08, 8'he0, 8'h25};

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t                state_q, state_d;
    logic [NPAR-1:0][7:0]  r_q, r_d;
    logic [NPAR-1:0][7:0]  r_base;
    logic [CW-1:0]         count_q, count_d, count_inc;
    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [7:0]            dout_q, dout_d;
    logic                  dout_val_q, dout_val_d;
    logic                  dout_sop_q, dout_sop_d;
    logic                  dout_eop_q, dout_eop_d;
    logic                  len_err_q, len_err_d;
    logic                  sop_err_q, sop_err_d;
    logic                  start;
    logic                  accept;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [NPAR-1:0][7:0] lfsr_step(input logic [NPAR-1:0][7:0] r,
                                                       input logic [7:0] d);
        logic [7:0]           fb;
        logic [NPAR-1:0][7:0] n;
        fb   = d ^ r[NPAR-1];
        n[0] = gf_mul(fb, G[0]);
        for (int i = 1; i < NPAR; i++) begin
            n[i] = r[i-1] ^ gf_mul(fb, G[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        dout_d     = 8'h00;
        dout_val_d = 1'b0;
        dout_sop_d = 1'b0;
        dout_eop_d = 1'b0;
        len_err_d  = 1'b0;
        sop_err_d  = 1'b0;
        accept     = 1'b0;
        start      = io.din_val && io.din_sop;
        // a sop byte always restarts the division, even mid-message
        r_base     = start ? '0 : r_q;
        count_inc  = start ? CW'(1) : count_q + CW'(1);

        case (state_q)
            IDLE: begin
                accept = start;
            end
            DATA: begin
                accept    = io.din_val;
                sop_err_d = start;
            end
            PARITY: begin
                dout_val_d = 1'b1;
                dout_d     = r_q[NPAR-1];
                r_d        = {r_q[NPAR-2:0], 8'h00};
                pcnt_d     = pcnt_q + PW'(1);
                sop_err_d  = start;
                if (pcnt_q == PW'(NPAR - 1)) begin
                    dout_eop_d = 1'b1;
                    state_d    = IDLE;
                    r_d        = '0;
                    count_d    = '0;
                    pcnt_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            r_d        = lfsr_step(r_base, io.din);
            count_d    = count_inc;
            dout_val_d = 1'b1;
            dout_d     = io.din;
            dout_sop_d = start;
            // hitting K bytes without eop closes the message anyway
            if (io.din_eop || count_inc == CW'(K)) begin
                state_d   = PARITY;
                pcnt_d    = '0;
                len_err_d = !io.din_eop;
            end else begin
                state_d = DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            dout_q     <= 8'h00;
            dout_val_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            len_err_q  <= 1'b0;
            sop_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            dout_q     <= dout_d;
            dout_val_q <= dout_val_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            len_err_q  <= len_err_d;
            sop_err_q  <= sop_err_d;
        end
    end

    assign io.dout     = dout_q;
    assign io.dout_val = dout_val_q;
    assign io.dout_sop = dout_sop_q;
    assign io.dout_eop = dout_eop_q;
    assign io.len_err  = len_err_q;
    assign io.sop_err  = sop_err_q;
    assign io.busy     = (state_q == PARITY);
endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder: self-checking bench for rs_encoder. Expected codeword bytes
// are pushed to a scoreboard queue as stimulus is driven and popped as the
// DUT emits them. Parity comes from a table of hand-derived vectors or from
// a log/antilog long-division model; every codeword is also checked for
// zero syndromes at a^1..a^8.
module tb_rs_encoder;
    localparam int K = 247;

    logic clk = 1'b0;
    logic rst;

    rs_encoder_if io();

    rs_encoder #(.K(K), .NPAR(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    typedef struct {
        int          len;
        logic [7:0]  last;
        bit          use_eop;
        logic [63:0] par;
        int          lerr;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[7];
    int         n_vec = 0;
    int         n_err = 0;
    int         gexp[0:509];
    int         glog[0:255];
    int         ga[0:8];
    logic [7:0] msg[0:255];
    int         busy_cnt = 0;
    int         lerr_cnt = 0;
    int         serr_cnt = 0;
    logic [7:0] cw[0:299];
    int         cw_len = 0;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   s;
        int   syn_or;
        if (io.dout_val === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got byte %0h with nothing expected", io.dout);
            end else begin
                e = sb.pop_front();
                check("dout{d,sop,eop}", int'({io.dout, io.dout_sop, io.dout_eop}), int'(e));
            end
            if (io.dout_sop) cw_len = 0;
            if (cw_len < 300) cw[cw_len] = io.dout;
            cw_len++;
            if (io.dout_eop) begin
                syn_or = 0;
                for (int j = 1; j <= 8; j++) begin
                    s = 0;
                    for (int i = 0; i < cw_len && i < 300; i++) s = gmul(s, gexp[j]) ^ int'(cw[i]);
                    syn_or |= s;
                end
                check("syndrome", syn_or, 0);
            end
        end else begin
            check("idle_zero", int'({io.dout, io.dout_sop, io.dout_eop}), 0);
        end
        busy_cnt += int'(io.busy);
        lerr_cnt += int'(io.len_err);
        serr_cnt += int'(io.sop_err);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_par(input int len);
        int          c[0:263];
        int          coef;
        logic [63:0] p;
        for (int i = 0; i < len; i++) c[i] = int'(msg[i]);
        for (int i = len; i < len + 8; i++) c[i] = 0;
        for (int i = 0; i < len; i++) begin
            coef = c[i];
            if (coef != 0)
                for (int j = 1; j <= 8; j++) c[i+j] ^= gmul(coef, ga[8-j]);
        end
        p = '0;
        for (int q = 0; q < 8; q++) p = {p[55:0], 8'(c[len+q])};
        return p;
    endfunction

    task automatic send_pkt(input int len, input bit use_eop, input bit gaps,
                            input bit push_par, input logic [63:0] par);
        int   t;
        exp_t e;
        t = 0;
        while (io.busy && t < 40) begin
            tick();
            t++;
        end
        check("ready_before_sop", int'(io.busy), 0);
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0)
                while ($urandom_range(3) == 0) tick();
            io.din_val = 1'b1;
            io.din_sop = (i == 0);
            io.din_eop = use_eop && (i == len - 1);
            io.din     = msg[i];
            e.d = msg[i]; e.sop = (i == 0); e.eop = 1'b0;
            sb.push_back(e);
            if (i == len - 1 && push_par) begin
                for (int q = 0; q < 8; q++) begin
                    e.d = par[63 - 8*q -: 8]; e.sop = 1'b0; e.eop = (q == 7);
                    sb.push_back(e);
                end
            end
            tick();
            io.din_val = 1'b0;
            io.din_sop = 1'b0;
            io.din_eop = 1'b0;
            io.din     = 8'h00;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 600) begin
            tick();
            t++;
        end
        check("drain_remaining", sb.size(), 0);
        sb.delete();
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(255));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          x;
        int          root;
        int          b0, l0, s0, len;
        logic [63:0] par;
        logic [63:0] pq[$];
        int          lq[$];

        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x; gexp[i+255] = x; glog[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11d;
        end
        glog[0] = 0;
        ga[0] = 1;
        for (int k = 1; k <= 8; k++) ga[k] = 0;
        for (int r = 1; r <= 8; r++) begin
            root = gexp[r];
            for (int k = 8; k >= 1; k--) ga[k] = ga[k-1] ^ gmul(ga[k], root);
            ga[0] = gmul(ga[0], root);
        end

        vt[0] = '{247, 8'h00, 1'b1, 64'h0000000000000000, 0};
        vt[1] = '{247, 8'h01, 1'b1, 64'he32cb247ac08e025, 0};
        vt[2] = '{1,   8'h01, 1'b1, 64'he32cb247ac08e025, 0};
        vt[3] = '{1,   8'h02, 1'b1, 64'hdb58798e4510dd4a, 0};
        vt[4] = '{247, 8'h00, 1'b0, 64'h0000000000000000, 1};
        vt[5] = '{10,  8'h01, 1'b1, 64'he32cb247ac08e025, 0};
        vt[6] = '{247, 8'h02, 1'b0, 64'hdb58798e4510dd4a, 1};

        io.din_val = 1'b0; io.din_sop = 1'b0; io.din_eop = 1'b0; io.din = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_dout_val", int'(io.dout_val), 0);
        check("rst_dout", int'(io.dout), 0);
        check("rst_busy", int'(io.busy), 0);
        check("rst_len_err", int'(io.len_err), 0);
        check("rst_sop_err", int'(io.sop_err), 0);

        // table vectors: zero messages with a single nonzero last byte
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 256; i++) msg[i] = 8'h00;
            msg[vt[v].len - 1] = vt[v].last;
            b0 = busy_cnt; l0 = lerr_cnt; s0 = serr_cnt;
            send_pkt(vt[v].len, vt[v].use_eop, 1'b0, 1'b1, vt[v].par);
            drain();
            check("busy_cycles", busy_cnt - b0, 8);
            check("len_err_pulses", lerr_cnt - l0, vt[v].lerr);
            check("sop_err_pulses", serr_cnt - s0, 0);
        end

        // full-length random message with input gaps
        fill_random(K);
        b0 = busy_cnt;
        send_pkt(K, 1'b1, 1'b1, 1'b1, model_par(K));
        drain();
        check("busy_cycles_rand", busy_cnt - b0, 8);

        // back-to-back random short packets, each sop in the first IDLE cycle
        s0 = serr_cnt;
        for (int p = 0; p < 4; p++) begin
            len = $urandom_range(60, 1);
            fill_random(len);
            send_pkt(len, 1'b1, p[0], 1'b1, model_par(len));
        end
        drain();
        check("b2b_sop_err", serr_cnt - s0, 0);

        // sop mid-message: abort, no parity, restart
        s0 = serr_cnt;
        fill_random(20);
        send_pkt(20, 1'b0, 1'b1, 1'b0, 64'h0);
        fill_random(30);
        send_pkt(30, 1'b1, 1'b0, 1'b1, model_par(30));
        drain();
        check("abort_sop_err", serr_cnt - s0, 1);

        // sop during parity: dropped, parity unchanged
        fill_random(12);
        s0 = serr_cnt; b0 = busy_cnt;
        send_pkt(12, 1'b1, 1'b0, 1'b1, model_par(12));
        tick();
        io.din_val = 1'b1; io.din_sop = 1'b1; io.din = 8'h55;
        tick();
        io.din_val = 1'b0; io.din_sop = 1'b0; io.din = 8'h00;
        drain();
        check("parity_sop_err", serr_cnt - s0, 1);
        check("parity_busy_cycles", busy_cnt - b0, 8);

        // reset while parity byte 3 is on dout
        fill_random(5);
        send_pkt(5, 1'b1, 1'b0, 1'b1, model_par(5));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_dout_val", int'(io.dout_val), 0);
        check("rst_mid_busy", int'(io.busy), 0);
        rst = 1'b0;
        sb.delete();
        repeat (3) tick();

        // LFSR must be clean after the abandoned codeword
        msg[0] = 8'h01;
        send_pkt(1, 1'b1, 1'b0, 1'b1, 64'he32cb247ac08e025);
        drain();

        pq.delete(); lq.delete();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
